// File: rtl/dt_pkg.sv
// Shared types and constants for the DT scan sequencer.
// Neighbour offsets are modulo-2^14 address deltas.
package dt_pkg;

  localparam int IMG_DIM = 128;
  localparam int RES_AW  = 14;
  localparam int STI_AW  = 10;
  localparam int DATA_W  = 8;

  localparam logic [6:0] IN_FIRST = 7'd1;
  localparam logic [6:0] IN_LAST  = 7'(IMG_DIM - 2);

  localparam logic [RES_AW-1:0] OFS_NW = RES_AW'(-129);
  localparam logic [RES_AW-1:0] OFS_N  = RES_AW'(-128);
  localparam logic [RES_AW-1:0] OFS_NE = RES_AW'(-127);
  localparam logic [RES_AW-1:0] OFS_SW = RES_AW'(127);
  localparam logic [RES_AW-1:0] OFS_S  = RES_AW'(128);
  localparam logic [RES_AW-1:0] OFS_SE = RES_AW'(129);

  typedef enum logic [3:0] {
    IDLE,
    FW_STI,
    FW_STI_LAT,
    FW_PIX,
    FW_RD_NW,
    FW_RD_N,
    FW_RD_NE,
    FW_WR,
    BW_RD_C,
    BW_RD_SW,
    BW_RD_S,
    BW_RD_SE,
    BW_WR,
    DONE
  } state_t;

endpackage

// File: rtl/dt_min_sat.sv
// Four-input minimum plus one, saturating at the top
// of the distance range.
module dt_min_sat
  import dt_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] y
);

  logic [DATA_W-1:0] m0;
  logic [DATA_W-1:0] m1;
  logic [DATA_W-1:0] m;

  always_comb begin
    m0 = (a < b) ? a : b;
    m1 = (c < d) ? c : d;
    m  = (m0 < m1) ? m0 : m1;
    y  = (m == '1) ? m : m + DATA_W'(1);
  end

endmodule

// File: rtl/dt_scan_seq.sv
// Two-pass chessboard distance transform sequencer:
// sti ROM unpack, res RAM neighbour reads and writes.
module dt_scan_seq
  import dt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  output logic              sti_rd,
  output logic [STI_AW-1:0] sti_addr,
  input  logic [15:0]       sti_di,
  output logic              res_rd,
  output logic              res_wr,
  output logic [RES_AW-1:0] res_addr,
  output logic [DATA_W-1:0] res_do,
  input  logic [DATA_W-1:0] res_di,
  output logic              fwpass_finish,
  output logic              done
);

  state_t state, state_d;

  logic [6:0]  row, row_d;
  logic [6:0]  col, col_d;
  logic [15:0] sh, sh_d;
  logic [DATA_W-1:0] w, w_d;
  logic [DATA_W-1:0] e, e_d;
  logic [DATA_W-1:0] nb0, nb0_d;
  logic [DATA_W-1:0] nb1, nb1_d;
  logic [DATA_W-1:0] nb2, nb2_d;
  logic [DATA_W-1:0] cur, cur_d;

  logic              sti_rd_d;
  logic [STI_AW-1:0] sti_addr_d;
  logic              res_rd_d;
  logic              res_wr_d;
  logic [RES_AW-1:0] res_addr_d;
  logic [DATA_W-1:0] res_do_d;
  logic              fin_d;
  logic              done_d;

  logic [RES_AW-1:0] pix;
  logic              border;
  logic              fw_step;
  logic              bw_step;
  logic [DATA_W-1:0] mc;
  logic [DATA_W-1:0] md;
  logic [DATA_W-1:0] mins;
  logic [DATA_W-1:0] bw_val;

  assign pix    = {row, col};
  assign border = (row == '0) || (row == '1) ||
                  (col == '0) || (col == '1);

  // fw uses captured NE and W; bw feeds SE live from the RAM
  always_comb begin
    mc = (state == FW_WR) ? nb2 : res_di;
    md = (state == FW_WR) ? w : e;
  end

  dt_min_sat u_min (
    .a (nb0),
    .b (nb1),
    .c (mc),
    .d (md),
    .y (mins)
  );

  assign bw_val = (cur < mins) ? cur : mins;

  always_comb begin
    state_d    = state;
    row_d      = row;
    col_d      = col;
    sh_d       = sh;
    w_d        = w;
    e_d        = e;
    nb0_d      = nb0;
    nb1_d      = nb1;
    nb2_d      = nb2;
    cur_d      = cur;
    sti_rd_d   = 1'b0;
    sti_addr_d = sti_addr;
    res_rd_d   = 1'b0;
    res_wr_d   = 1'b0;
    res_addr_d = res_addr;
    res_do_d   = res_do;
    fin_d      = fwpass_finish;
    done_d     = done;
    fw_step    = 1'b0;
    bw_step    = 1'b0;

    unique case (state)
      IDLE: state_d = FW_STI;
      FW_STI: begin
        sti_rd_d   = 1'b1;
        sti_addr_d = {row, col[6:4]};
        state_d    = FW_STI_LAT;
      end
      FW_STI_LAT: begin
        sh_d    = sti_di;
        state_d = FW_PIX;
      end
      FW_PIX: begin
        if (!sh[15] || border) begin
          res_wr_d   = 1'b1;
          res_addr_d = pix;
          res_do_d   = '0;
          w_d        = '0;
          fw_step    = 1'b1;
        end else begin
          res_rd_d   = 1'b1;
          res_addr_d = pix + OFS_NW;
          state_d    = FW_RD_NW;
        end
      end
      FW_RD_NW: begin
        nb0_d      = res_di;
        res_rd_d   = 1'b1;
        res_addr_d = pix + OFS_N;
        state_d    = FW_RD_N;
      end
      FW_RD_N: begin
        nb1_d      = res_di;
        res_rd_d   = 1'b1;
        res_addr_d = pix + OFS_NE;
        state_d    = FW_RD_NE;
      end
      FW_RD_NE: begin
        nb2_d   = res_di;
        state_d = FW_WR;
      end
      FW_WR: begin
        res_wr_d   = 1'b1;
        res_addr_d = pix;
        res_do_d   = mins;
        w_d        = mins;
        fw_step    = 1'b1;
      end
      BW_RD_C: begin
        res_rd_d   = 1'b1;
        res_addr_d = pix;
        state_d    = BW_RD_SW;
      end
      BW_RD_SW: begin
        if (res_di == '0) begin
          e_d     = '0;
          bw_step = 1'b1;
        end else begin
          cur_d      = res_di;
          res_rd_d   = 1'b1;
          res_addr_d = pix + OFS_SW;
          state_d    = BW_RD_S;
        end
      end
      BW_RD_S: begin
        nb0_d      = res_di;
        res_rd_d   = 1'b1;
        res_addr_d = pix + OFS_S;
        state_d    = BW_RD_SE;
      end
      BW_RD_SE: begin
        nb1_d      = res_di;
        res_rd_d   = 1'b1;
        res_addr_d = pix + OFS_SE;
        state_d    = BW_WR;
      end
      BW_WR: begin
        res_wr_d   = 1'b1;
        res_addr_d = pix;
        res_do_d   = bw_val;
        e_d        = bw_val;
        bw_step    = 1'b1;
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase

    if (fw_step) begin
      sh_d = {sh[14:0], 1'b0};
      if (pix == '1) begin
        fin_d   = 1'b1;
        row_d   = IN_LAST;
        col_d   = IN_LAST;
        e_d     = '0;
        state_d = BW_RD_C;
      end else begin
        {row_d, col_d} = pix + RES_AW'(1);
        state_d = (&col[3:0]) ? FW_STI : FW_PIX;
      end
    end

    // backward pass walks interior pixels only
    if (bw_step) begin
      state_d = BW_RD_C;
      if (col == IN_FIRST) begin
        if (row == IN_FIRST) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          row_d = row - 7'd1;
          col_d = IN_LAST;
          e_d   = '0;
        end
      end else begin
        col_d = col - 7'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      row           <= '0;
      col           <= '0;
      sh            <= '0;
      w             <= '0;
      e             <= '0;
      nb0           <= '0;
      nb1           <= '0;
      nb2           <= '0;
      cur           <= '0;
      sti_rd        <= 1'b0;
      sti_addr      <= '0;
      res_rd        <= 1'b0;
      res_wr        <= 1'b0;
      res_addr      <= '0;
      res_do        <= '0;
      fwpass_finish <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_d;
      row           <= row_d;
      col           <= col_d;
      sh            <= sh_d;
      w             <= w_d;
      e             <= e_d;
      nb0           <= nb0_d;
      nb1           <= nb1_d;
      nb2           <= nb2_d;
      cur           <= cur_d;
      sti_rd        <= sti_rd_d;
      sti_addr      <= sti_addr_d;
      res_rd        <= res_rd_d;
      res_wr        <= res_wr_d;
      res_addr      <= res_addr_d;
      res_do        <= res_do_d;
      fwpass_finish <= fin_d;
      done          <= done_d;
    end
  end

endmodule
